// File: rtl/sqrt_pkg.sv
// Shared types and width helpers for the iterative square-root sequencer.
// Provides the FSM state enum, root width (WIDTH/2) and counter width helpers.
package sqrt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } sqrt_state_t;

    function automatic int rootWidth(input int w);
        return w / 2;
    endfunction

    // Counter only needs to reach n-1; keep at least one bit.
    function automatic int cntWidth(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sqrt_sub_row.sv
// Ripple borrow-subtract row: diff = minuend - subtrahend, built from 1-bit cells.
// Ports: minuend/subtrahend [W-1:0] in; diff [W-1:0], borrowOut out.
module sqrt_sub_cell (
    input  logic a,
    input  logic b,
    input  logic borrowIn,
    output logic d,
    output logic borrowOut
);
    assign d         = a ^ b ^ borrowIn;
    assign borrowOut = (~a & b) | (~(a ^ b) & borrowIn);
endmodule

module sqrt_sub_row #(
    parameter int W = 14
) (
    input  logic [W-1:0] minuend,
    input  logic [W-1:0] subtrahend,
    output logic [W-1:0] diff,
    output logic         borrowOut
);
    logic [W:0] borrow;

    assign borrow[0] = 1'b0;

    for (genvar i = 0; i < W; i++) begin : gCell
        sqrt_sub_cell uCell (
            .a         (minuend[i]),
            .b         (subtrahend[i]),
            .borrowIn  (borrow[i]),
            .d         (diff[i]),
            .borrowOut (borrow[i+1])
        );
    end

    assign borrowOut = borrow[W];
endmodule

// File: rtl/sqrt_iter_ctrl.sv
// Iterative restoring square root, one root bit per cycle over a shared subtract row.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready/in_radicand; out_valid/out_ready/out_root/out_rem/out_exact; busy.
module sqrt_iter_ctrl
    import sqrt_pkg::*;
#(
    parameter int WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_radicand,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH/2-1:0]   out_root,
    output logic [WIDTH/2:0]     out_rem,
    output logic                 out_exact,
    output logic                 busy
);
    localparam int N  = rootWidth(WIDTH);
    localparam int CW = cntWidth(N);

    sqrt_state_t state, nextState;

    logic [WIDTH-1:0] rad;
    logic [N:0]       rem;
    logic [N-1:0]     root;
    logic [CW-1:0]    cnt;

    logic           accept;
    logic           lastIter;
    logic [N+1:0]   minuend;
    logic [N+1:0]   subtrahend;
    logic [N+1:0]   diff;
    logic           borrow;
    logic           unusedDiffMsb;

    // rem stays below 2^N until the final iteration has run, so its
    // low N bits are the whole partial remainder when it feeds the row.
    assign minuend    = {rem[N-1:0], rad[WIDTH-1:WIDTH-2]};
    assign subtrahend = {root, 2'b01};

    sqrt_sub_row #(
        .W (N + 2)
    ) uSubRow (
        .minuend    (minuend),
        .subtrahend (subtrahend),
        .diff       (diff),
        .borrowOut  (borrow)
    );

    // A successful trial always leaves the top difference bit clear.
    assign unusedDiffMsb = diff[N+1];

    assign accept   = in_valid & in_ready;
    assign lastIter = (cnt == CW'(N - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    if (accept)                 nextState = CALC;
            CALC:    if (lastIter)               nextState = DONE;
            DONE:    if (out_valid && out_ready) nextState = IDLE;
            default:                             nextState = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE:    in_ready  = 1'b1;
            CALC:    busy      = 1'b1;
            DONE:    out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rad  <= '0;
            rem  <= '0;
            root <= '0;
            cnt  <= '0;
        end else if (accept) begin
            rad  <= in_radicand;
            rem  <= '0;
            root <= '0;
            cnt  <= '0;
        end else if (state == CALC) begin
            if (!borrow) rem <= diff[N:0];
            else         rem <= {rem[N-2:0], rad[WIDTH-1:WIDTH-2]};
            root <= {root[N-2:0], ~borrow};
            rad  <= rad << 2;
            cnt  <= cnt + 1'b1;
        end
    end

    assign out_root  = root;
    assign out_rem   = rem;
    assign out_exact = (rem == '0);
endmodule

// File: doc/sqrt_iter_ctrl.md
# sqrt_iter_ctrl

Iterative integer square-root sequencer for the floating-point ALU square-root path. It accepts an unsigned radicand over a valid/ready handshake and runs one restoring-subtract row per cycle, producing one root bit per iteration. It returns root, remainder and an exact flag over a second valid/ready handshake. It sits between the FP sqrt front end (exponent halving, mantissa alignment) and the rounding/normalisation stage, and time-shares a single row of borrow-subtract cells instead of a full array.

## Interface
- `WIDTH`, default 24: radicand width in bits. Must be even and ≥ 4. `N = WIDTH/2` is the root width.
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `in_valid` input 1: radicand on `in_radicand` is valid.
- `in_ready` output 1: block can accept a radicand.
- `in_radicand` input WIDTH: unsigned radicand.
- `out_valid` output 1: result is valid.
- `out_ready` input 1: downstream accepts the result.
- `out_root` output N: floor(sqrt(radicand)).
- `out_rem` output N+1: radicand − root².
- `out_exact` output 1: `out_rem == 0`.
- `busy` output 1: high in CALC.

## Operation
- FSM states: IDLE, CALC, DONE.
  - IDLE → CALC on `in_valid & in_ready`.
  - CALC → DONE when the iteration counter reaches N−1 and that iteration completes.
  - DONE → IDLE on `out_valid & out_ready`.
- `in_ready = (state == IDLE)`.
- `out_valid = (state == DONE)`.
- `busy = (state == CALC)`.
- On accept:
  - Radicand shift register loads `in_radicand`.
  - `rem`, `root` and `cnt` load 0.
- Each CALC cycle performs one iteration:
  - `trial = {rem, rad[WIDTH-1:WIDTH-2]} − {root, 2'b01}`, computed N+2 bits wide.
  - If there is no borrow out of the MSB: `rem ← trial[N:0]`, `root ← {root[N-2:0], 1}`.
  - Otherwise: `rem ← {rem, rad[WIDTH-1:WIDTH-2]}[N:0]`, `root ← {root[N-2:0], 0}`.
  - Then `rad ← rad << 2` and `cnt ← cnt + 1`.
- Invariant: `rem ≤ 2·root`, so N+1 bits never overflow. The trial MSB is the borrow.
- `out_root`, `out_rem` and `out_exact` are driven from registers and hold stable throughout DONE, independent of inputs.
- Back-pressure: with `out_ready` low, DONE persists indefinitely and the result holds. `in_valid` is ignored because `in_ready` is 0.
- `in_valid` during CALC or DONE is not accepted. The upstream must hold it until `in_ready`.
- No input is accepted in the same cycle a result is consumed. Throughput is one result per N+2 cycles minimum.
- Radicand 0 is not special-cased. It runs the full N iterations.

## Timing
- Reset (`rst_n` low at a rising edge):
  - State goes to IDLE, `cnt = 0`.
  - `out_root = 0`, `out_rem = 0`, `out_exact = 1`, `out_valid = 0`, `busy = 0`, `in_ready = 1`.
- Reset during CALC or DONE aborts the operation immediately and discards the result. No `out_valid` follows.
- Latency: accept on edge k. CALC spans edges k+1 … k+N. `out_valid` is high from the cycle after edge k+N, i.e. N cycles after acceptance.
- Earliest next accept: the edge after the consuming edge.
- The trial subtract is a single combinational N+2-bit borrow chain per cycle. It is the critical path, and no pipelining is applied.

## Structure
- Shared package `sqrt_pkg`:
  - `sqrt_state_t` enum (IDLE, CALC, DONE).
  - Helper constant function for N from WIDTH.
- Sub-module `sqrt_sub_row`:
  - Parameterised N+2-bit ripple subtract row built from the existing 1-bit borrow/difference cells.
  - Inputs: minuend, subtrahend.
  - Outputs: difference, borrow-out.
  - Instantiated once and reused every cycle.
- The controller contains the FSM, counter, shift register, and the `rem`/`root` registers.

## Test plan
- Reset then idle, all with `WIDTH=24`: hold `rst_n` low 2 cycles → `in_ready=1`, `out_valid=0`, `out_root=0`, `out_rem=0`, `out_exact=1`.
- Exact square: radicand 144 → after 12 cycles `out_valid=1`, `out_root=12`, `out_rem=0`, `out_exact=1`.
- Boundaries:
  - Radicand 0 → root 0, rem 0, exact 1.
  - Radicand 2 → root 1, rem 1, exact 0.
  - Radicand 0xFFFFFF → root 4095, rem 8190, exact 0.
- Back-pressure: hold `out_ready=0` for 20 cycles after `out_valid` with `in_valid` toggling → result stable, `in_ready=0`, no new accept. Release → next radicand accepted the following edge.
- Reset mid-CALC: assert `rst_n` low at iteration 5 of radicand 1000 → IDLE next edge, no `out_valid`. A fresh radicand 1000 gives root 31, rem 39.
- Random regression: 10k random radicands with random `out_ready` stalls → `out_root² + out_rem == radicand` and `out_rem ≤ 2·out_root`. Latency is exactly 12 cycles from accept to `out_valid`.
